// File: rtl/vga_timing_gen_if.sv
// Raster-side bundle for vga_timing_gen: the timing-set request goes in, and counters,
// syncs and strobes come out.
interface vga_timing_gen_if #(parameter int W = 12);
  logic         mode_sel;
  logic         mode_cur;
  logic [W-1:0] hc;
  logic [W-1:0] vc;
  logic         hsync;
  logic         vsync;
  logic         vidon;
  logic         sol;
  logic         sof;
  logic [15:0]  frame_cnt;

  modport master (input mode_sel,
                  output mode_cur, hc, vc, hsync, vsync, vidon, sol, sof, frame_cnt);
  modport slave  (output mode_sel,
                  input mode_cur, hc, vc, hsync, vsync, vidon, sol, sof, frame_cnt);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two runtime timing sets, per-set sync polarity, DLY-stage output delay.
// The frame counter is built only when VGA_TIMING_FRAMECNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
  parameter int W      = 12,
  parameter int A_HACT = 1024, parameter int A_HFP = 24, parameter int A_HSP = 136, parameter int A_HBP = 160,
  parameter int A_VACT = 768,  parameter int A_VFP = 3,  parameter int A_VSP = 6,   parameter int A_VBP = 29,
  parameter bit A_HPOL = 1'b0, parameter bit A_VPOL = 1'b0,
  parameter int B_HACT = 640,  parameter int B_HFP = 16, parameter int B_HSP = 96,  parameter int B_HBP = 48,
  parameter int B_VACT = 480,  parameter int B_VFP = 10, parameter int B_VSP = 2,   parameter int B_VBP = 33,
  parameter bit B_HPOL = 1'b0, parameter bit B_VPOL = 1'b0,
  parameter int DLY    = 0
) (
  input  logic             clk,
  input  logic             clr,
  vga_timing_gen_if.master vif
);
  localparam int A_HTOT_I = A_HACT + A_HFP + A_HSP + A_HBP;
  localparam int A_VTOT_I = A_VACT + A_VFP + A_VSP + A_VBP;
  localparam int B_HTOT_I = B_HACT + B_HFP + B_HSP + B_HBP;
  localparam int B_VTOT_I = B_VACT + B_VFP + B_VSP + B_VBP;

  generate
    if (A_HTOT_I >= (1 << W) || A_VTOT_I >= (1 << W) ||
        B_HTOT_I >= (1 << W) || B_VTOT_I >= (1 << W)) begin : g_bad_width
      $fatal(1, "vga_timing_gen: timing totals do not fit in W bits");
    end
    if (DLY < 0 || DLY > 7) begin : g_bad_dly
      $fatal(1, "vga_timing_gen: DLY must be 0..7");
    end
  endgenerate

  localparam int A_HS0_I = A_HACT + A_HFP;
  localparam int A_HS1_I = A_HS0_I + A_HSP;
  localparam int A_VS0_I = A_VACT + A_VFP;
  localparam int A_VS1_I = A_VS0_I + A_VSP;
  localparam int B_HS0_I = B_HACT + B_HFP;
  localparam int B_HS1_I = B_HS0_I + B_HSP;
  localparam int B_VS0_I = B_VACT + B_VFP;
  localparam int B_VS1_I = B_VS0_I + B_VSP;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  // Output word layout: {hsync, vsync, vidon, sol, sof}
  localparam logic [4:0]   IDLE = {~A_HPOL, ~A_VPOL, 3'b000};

  logic [W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic         mode_q, mode_d;
  logic [W-1:0] htot, vtot, hact, vact, hs0, hs1, vs0, vs1;
  logic         hpol, vpol;
  logic         last_h, frame_end;
  logic [4:0]   dec;
  logic [4:0]   pipe_q [0:DLY];

  always_comb begin
    htot = A_HTOT_I[W-1:0];
    vtot = A_VTOT_I[W-1:0];
    hact = A_HACT[W-1:0];
    vact = A_VACT[W-1:0];
    hs0  = A_HS0_I[W-1:0];
    hs1  = A_HS1_I[W-1:0];
    vs0  = A_VS0_I[W-1:0];
    vs1  = A_VS1_I[W-1:0];
    hpol = A_HPOL;
    vpol = A_VPOL;
    if (mode_q) begin
      htot = B_HTOT_I[W-1:0];
      vtot = B_VTOT_I[W-1:0];
      hact = B_HACT[W-1:0];
      vact = B_VACT[W-1:0];
      hs0  = B_HS0_I[W-1:0];
      hs1  = B_HS1_I[W-1:0];
      vs0  = B_VS0_I[W-1:0];
      vs1  = B_VS1_I[W-1:0];
      hpol = B_HPOL;
      vpol = B_VPOL;
    end
  end

  assign last_h    = (hc_q == htot - ONE);
  assign frame_end = last_h && (vc_q == vtot - ONE);

  // The requested set is only taken at the frame boundary, so a frame never mixes totals.
  always_comb begin
    hc_d   = last_h ? '0 : hc_q + ONE;
    vc_d   = vc_q;
    mode_d = mode_q;
    if (last_h) vc_d = frame_end ? '0 : vc_q + ONE;
    if (frame_end) mode_d = vif.mode_sel;
  end

  // Polarity is chosen from the set that produced hc/vc, so it travels down the pipe with them.
  always_comb begin
    dec    = {~hpol, ~vpol, 3'b000};
    if (hc_q >= hs0 && hc_q < hs1) dec[4] = hpol;
    if (vc_q >= vs0 && vc_q < vs1) dec[3] = vpol;
    dec[2] = (hc_q < hact) && (vc_q < vact);
    dec[1] = (hc_q == '0);
    dec[0] = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc_q   <= '0;
      vc_q   <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i <= DLY; i++) pipe_q[i] <= IDLE;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      mode_q    <= mode_d;
      pipe_q[0] <= dec;
      for (int i = 1; i <= DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vif.mode_cur = mode_q;
  assign vif.hc       = hc_q;
  assign vif.vc       = vc_q;
  assign {vif.hsync, vif.vsync, vif.vidon, vif.sol, vif.sof} = pipe_q[DLY];

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] fc_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)            fc_q <= 16'h0000;
    else if (frame_end) fc_q <= fc_q + 16'h0001;
  end

  assign vif.frame_cnt = fc_q;
`else
  assign vif.frame_cnt = 16'h0000;
`endif
endmodule
